// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-command valid/ready front end driving APB3 transfers.
// Define APB_TIMEOUT_EN to abort ACCESS phases that never see PREADY.
module apb_cmd_master #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_SLAVES     = 2,
  parameter int TIMEOUT_CYCLES = 255,
  localparam int SEL_WIDTH     = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                  PCLK,
  input  logic                  PRESETN,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [SEL_WIDTH-1:0]  cmd_sel,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  localparam logic [SEL_WIDTH:0] SEL_LIM =
    (SEL_WIDTH+1)'(NUM_SLAVES);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_to_range
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  logic [1:0]            state_q;
  logic [SEL_WIDTH-1:0]  sel_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic                  sel_ok;
  logic                  in_apb;

`ifdef APB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] cnt_q;
  logic        to_q;
  assign rsp_timeout = to_q;
`else
  assign rsp_timeout = 1'b0;
`endif

  assign sel_ok    = {1'b0, cmd_sel} < SEL_LIM;
  assign in_apb    = (state_q == SETUP) || (state_q == ACCESS);
  assign PSEL      = in_apb ? (NUM_SLAVES'(1) << sel_q) : '0;
  assign PENABLE   = (state_q == ACCESS);
  assign cmd_ready = (state_q == IDLE) && PRESETN;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Command/APB/response sequencing; an out-of-range select skips the bus.
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
`ifdef APB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            if (sel_ok) begin
              state_q <= SETUP;
              sel_q   <= cmd_sel;
              PWRITE  <= cmd_write;
              PADDR   <= cmd_addr;
              PWDATA  <= cmd_wdata;
            end else begin
              state_q <= RESP;
              rdata_q <= '0;
              err_q   <= 1'b1;
`ifdef APB_TIMEOUT_EN
              to_q    <= 1'b0;
`endif
            end
          end
        end
        SETUP: begin
          state_q <= ACCESS;
`ifdef APB_TIMEOUT_EN
          cnt_q   <= '0;
`endif
        end
        ACCESS: begin
          if (PREADY) begin
            state_q <= RESP;
            rdata_q <= PWRITE ? '0 : PRDATA;
            err_q   <= PSLVERR;
`ifdef APB_TIMEOUT_EN
            to_q    <= 1'b0;
          end else if (cnt_q == TO_LAST) begin
            state_q <= RESP;
            rdata_q <= '0;
            err_q   <= 1'b1;
            to_q    <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + 16'd1;
`endif
          end
        end
        RESP: begin
          if (rsp_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized and directed checks against a
// transaction-level model of the command/APB/response timeline.
module tb_apb_cmd_master;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int NS = 3;
  localparam int SW = 2;
  localparam int TO = 4;
  localparam int VW = NS + AW + DW + 4;
  localparam int RW = NS + DW + 5;
  localparam int ZW = NS + AW + DW + DW + 6;

  logic          PCLK = 1'b0;
  logic          PRESETN;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [SW-1:0] cmd_sel;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout;
  logic [NS-1:0] PSEL;
  logic          PENABLE, PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;
  logic          PREADY, PSLVERR;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  apb_cmd_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
    .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_sel(cmd_sel),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit            issued;
    int            access;
    logic [DW-1:0] rdata;
    bit            err;
    bit            tmo;
  } exp_t;

  // Outcome of one command from the bus rules alone.
  function automatic exp_t model(bit w, int sel, int waits,
                                 logic [DW-1:0] prd, bit slverr,
                                 bit stuck);
    exp_t e;
    e.issued = (sel < NS);
    e.access = 0;
    e.rdata  = '0;
    e.err    = 1'b1;
    e.tmo    = 1'b0;
    if (!e.issued) return e;
`ifdef APB_TIMEOUT_EN
    if (stuck || waits >= TO) begin
      e.access = TO;
      e.tmo    = 1'b1;
      return e;
    end
`endif
    e.access = waits + 1;
    e.rdata  = w ? '0 : prd;
    e.err    = slverr;
    return e;
  endfunction

  task automatic run_cmd(input bit w, input int sel,
                         input logic [AW-1:0] addr,
                         input logic [DW-1:0] wd,
                         input int waits,
                         input logic [DW-1:0] prd,
                         input bit slverr, input int hold,
                         input bit stuck,
                         output int hs, output int re);
    exp_t e;
    int k, j;
    bit done;
    logic [NS-1:0] oh;
    logic [VW-1:0] gv, ev;
    logic [RW-1:0] gr, er;
    e  = model(w, sel, waits, prd, slverr, stuck);
    oh = '0;
    if (e.issued) oh[sel] = 1'b1;
    @(negedge PCLK);
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || PSEL !== '0) begin
      bad++;
      $display("FAIL idle_before_cmd got rdy=%b vld=%b psel=%b exp 1 0 0",
               cmd_ready, rsp_valid, PSEL);
    end
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_sel   = SW'(sel);
    cmd_addr  = addr;
    cmd_wdata = wd;
    PREADY    = 1'b0;
    rsp_ready = 1'b0;
    @(posedge PCLK);
    #1;
    hs = cyc;
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_sel   = SW'($urandom);
    k = 0;
    done = 1'b0;
    while (!done && k < 60) begin
      @(negedge PCLK);
      PRDATA  = DW'($urandom);
      PSLVERR = 1'($urandom);
      PREADY  = 1'b0;
      if (e.issued && k <= e.access) begin
        gv = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, cmd_ready};
        ev = {oh, (k != 0), w, addr, wd, 1'b0, 1'b0};
        total++;
        if (gv !== ev) begin
          bad++;
          $display("FAIL apb_phase k=%0d got=%h exp=%h", k, gv, ev);
        end
        rsp_ready = 1'($urandom);
        if (!stuck && k == waits + 1) begin
          PREADY  = 1'b1;
          PRDATA  = prd;
          PSLVERR = slverr;
        end
      end else begin
        j  = k - (e.issued ? e.access + 1 : 0);
        gr = {PSEL, PENABLE, rsp_valid, cmd_ready,
              rsp_rdata, rsp_err, rsp_timeout};
        er = {{NS{1'b0}}, 1'b0, 1'b1, 1'b0, e.rdata, e.err, e.tmo};
        total++;
        if (gr !== er) begin
          bad++;
          $display("FAIL rsp_phase j=%0d got=%h exp=%h", j, gr, er);
        end
        rsp_ready = (j >= hold);
        done = (j >= hold);
      end
      k++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL rsp_bound got=no_handshake exp=handshake");
    end
    @(posedge PCLK);
    #1;
    re = cyc;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
  endtask

  task automatic check_zero(input string nm);
    logic [ZW-1:0] g;
    g = {PSEL, PENABLE, PWRITE, PADDR, PWDATA, cmd_ready,
         rsp_valid, rsp_rdata, rsp_err, rsp_timeout};
    total++;
    if (g !== '0) begin
      bad++;
      $display("FAIL %s got=%h exp=0", nm, g);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge PCLK);
    check_zero("reset_values");
    PRESETN = 1'b1;
    @(negedge PCLK);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_reset got=%b exp=1", cmd_ready);
    end
  endtask

  task automatic test_write_nowait();
    int hs, re;
    run_cmd(1, 0, 5'h00, 8'hA5, 0, 8'h00, 0, 0, 0, hs, re);
    total++;
    if (re - hs !== 3) begin
      bad++;
      $display("FAIL write_latency got=%0d exp=3", re - hs);
    end
  endtask

  task automatic test_read_waits();
    int hs, re;
    run_cmd(0, 1, 5'h04, 8'h11, 3, 8'h3C, 0, 0, 0, hs, re);
  endtask

  task automatic test_errors();
    int hs, re;
    run_cmd(0, 2, 5'h1F, 8'h00, 1, 8'h77, 1, 0, 0, hs, re);
    run_cmd(1, 3, 5'h09, 8'h5A, 0, 8'h00, 0, 1, 0, hs, re);
    total++;
    if (re - hs !== 2) begin
      bad++;
      $display("FAIL badsel_latency got=%0d exp=2", re - hs);
    end
  endtask

  task automatic test_backpressure();
    int hs1, re1, hs2, re2;
    run_cmd(0, 0, 5'h12, 8'h00, 0, 8'hC3, 0, 10, 0, hs1, re1);
    run_cmd(1, 1, 5'h13, 8'h44, 0, 8'h00, 0, 0, 0, hs2, re2);
    total++;
    if (re1 - hs1 !== 13 || hs2 - re1 !== 1) begin
      bad++;
      $display("FAIL backpressure got=%0d,%0d exp=13,1",
               re1 - hs1, hs2 - re1);
    end
  endtask

  task automatic test_back_to_back();
    int hs1, re1, hs2, re2;
    run_cmd(1, 2, 5'h01, 8'h0F, 0, 8'h00, 0, 0, 0, hs1, re1);
    run_cmd(0, 0, 5'h02, 8'h00, 0, 8'hF0, 0, 0, 0, hs2, re2);
    total++;
    if (hs2 - hs1 !== 4) begin
      bad++;
      $display("FAIL cmd_period got=%0d exp=4", hs2 - hs1);
    end
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout();
    int hs, re;
    run_cmd(0, 1, 5'h07, 8'h00, 0, 8'h99, 0, 0, 1, hs, re);
    total++;
    if (re - hs !== TO + 2) begin
      bad++;
      $display("FAIL timeout_latency got=%0d exp=%0d", re - hs, TO + 2);
    end
    run_cmd(0, 0, 5'h08, 8'h00, TO - 1, 8'h66, 0, 0, 0, hs, re);
    run_cmd(1, 2, 5'h09, 8'h21, TO, 8'h00, 0, 0, 0, hs, re);
  endtask
`else
  task automatic test_no_timeout();
    int viol;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_sel   = '0;
    cmd_addr  = 5'h03;
    PREADY    = 1'b0;
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    @(negedge PCLK);
    viol = 0;
    repeat (1000) begin
      @(negedge PCLK);
      if (!(PSEL === 3'b001 && PENABLE === 1'b1 && rsp_valid === 1'b0))
        viol++;
    end
    total++;
    if (viol !== 0) begin
      bad++;
      $display("FAIL stuck_access got=%0d exp=0", viol);
    end
    #2;
    PRESETN = 1'b0;
    #1;
    check_zero("reset_from_stuck");
    @(negedge PCLK);
    PRESETN = 1'b1;
  endtask
`endif

  task automatic test_reset_mid();
    int hs, re;
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_sel   = 2'd1;
    cmd_addr  = 5'h15;
    cmd_wdata = 8'hE7;
    PREADY    = 1'b0;
    @(posedge PCLK);
    #1;
    cmd_valid = 1'b0;
    repeat (3) @(negedge PCLK);
    total++;
    if (PENABLE !== 1'b1) begin
      bad++;
      $display("FAIL mid_in_access got=%b exp=1", PENABLE);
    end
    #2;
    PRESETN = 1'b0;
    #1;
    check_zero("reset_mid_xfer");
    @(negedge PCLK);
    PRESETN = 1'b1;
    run_cmd(1, 0, 5'h1A, 8'h3D, 0, 8'h00, 0, 0, 0, hs, re);
  endtask

  task automatic test_random();
    int hs, re;
    repeat (40) begin
      run_cmd(1'($urandom), int'($urandom_range(0, 3)),
              AW'($urandom), DW'($urandom),
              int'($urandom_range(0, 5)), DW'($urandom),
              1'($urandom), int'($urandom_range(0, 2)), 0,
              hs, re);
    end
  endtask

  initial begin
    PRESETN   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_sel   = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;
    test_reset();
    test_write_nowait();
    test_read_waits();
    test_errors();
    test_backpressure();
    test_back_to_back();
`ifdef APB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
